// File: rtl/audio_pkg.sv
// Shared audio constants, NCO sizing helpers and the sample type for the I2S output path.
package audio_pkg;

   localparam int CLK_HZ_DEF      = 32_000_000;
   localparam int SAMPLE_RATE_DEF = 48_000;
   localparam int BITS_DEF        = 16;

   typedef logic signed [15:0] sample_t;

   // Tick rate is two per BCLK period (one per edge), 2*BITS BCLKs per frame.
   function automatic int nco_inc(input int sample_rate, input int bits);
      return 2 * sample_rate * 2 * bits;
   endfunction

   // One spare bit so acc + INC (both below CLK_HZ) never overflows.
   function automatic int nco_acc_w(input int clk_hz);
      return $clog2(clk_hz) + 1;
   endfunction

endpackage

// File: rtl/i2s_nco.sv
// Fractional phase accumulator: emits a one-cycle tick at exactly INC/CLK_HZ of the clk32 rate.
module i2s_nco
   import audio_pkg::*;
#(
   parameter int CLK_HZ = CLK_HZ_DEF,
   parameter int INC    = nco_inc(SAMPLE_RATE_DEF, BITS_DEF)
) (
   input  logic clk32,
   input  logic por,
   output logic tick
);

   localparam int ACC_W = nco_acc_w(CLK_HZ);
   localparam logic [ACC_W-1:0] INC_V = ACC_W'(INC);
   localparam logic [ACC_W-1:0] CLK_V = ACC_W'(CLK_HZ);

   if (INC >= CLK_HZ) begin : g_bad_inc
      $fatal(1, "i2s_nco: INC must be strictly below CLK_HZ");
   end

   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] acc_sum;

   assign acc_sum = acc + INC_V;
   assign tick    = (acc_sum >= CLK_V);

   always_ff @(posedge clk32) begin
      if (por) begin
         acc <= '0;
      end else if (tick) begin
         acc <= acc_sum - CLK_V;
      end else begin
         acc <= acc_sum;
      end
   end

endmodule

// File: rtl/i2s_tx.sv
// Stereo I2S transmitter: NCO-timed BCLK/LRCK, per-frame latch of both channels, MSB-first serialiser.
// Define I2S_LEFT_JUSTIFIED_EN for left-justified data (no one-BCLK data delay); default is Philips I2S.
module i2s_tx
   import audio_pkg::*;
#(
   parameter int CLK_HZ      = CLK_HZ_DEF,
   parameter int SAMPLE_RATE = SAMPLE_RATE_DEF,
   parameter int BITS        = BITS_DEF
) (
   input  logic            clk32,
   input  logic            por,
   input  logic [BITS-1:0] audio_l,
   input  logic [BITS-1:0] audio_r,
   output logic            sample_strobe,
   output logic            i2s_bclk,
   output logic            i2s_lrck,
   output logic            i2s_din
);

   localparam int INC   = nco_inc(SAMPLE_RATE, BITS);
   localparam int FRAME = 2 * BITS;
   localparam int CNT_W = $clog2(FRAME);

   logic             tick;
   logic             fall;
   logic [CNT_W-1:0] bit_cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic [FRAME-1:0] shreg;
   logic [FRAME-1:0] shreg_nxt;
`ifndef I2S_LEFT_JUSTIFIED_EN
   logic             lj_bit;
`endif

   i2s_nco #(
      .CLK_HZ (CLK_HZ),
      .INC    (INC)
   ) u_nco (
      .clk32 (clk32),
      .por   (por),
      .tick  (tick)
   );

   // Every data update rides on the BCLK falling edge.
   assign fall = tick & i2s_bclk;

   always_comb begin
      cnt_nxt   = (bit_cnt == CNT_W'(FRAME - 1)) ? '0 : bit_cnt + CNT_W'(1);
      shreg_nxt = {shreg[FRAME-2:0], 1'b0};
      if (cnt_nxt == '0) begin
         shreg_nxt = {audio_l, audio_r};
      end
   end

   assign sample_strobe = fall & ~por & (cnt_nxt == '0);

   always_ff @(posedge clk32) begin
      if (por) begin
         i2s_bclk <= 1'b0;
         i2s_lrck <= 1'b0;
         i2s_din  <= 1'b0;
         bit_cnt  <= '0;
         shreg    <= '0;
`ifndef I2S_LEFT_JUSTIFIED_EN
         lj_bit   <= 1'b0;
`endif
      end else if (tick) begin
         if (!i2s_bclk) begin
            i2s_bclk <= 1'b1;
         end else begin
            i2s_bclk <= 1'b0;
            bit_cnt  <= cnt_nxt;
            shreg    <= shreg_nxt;
            i2s_lrck <= (cnt_nxt >= CNT_W'(BITS));
`ifdef I2S_LEFT_JUSTIFIED_EN
            i2s_din  <= shreg_nxt[FRAME-1];
`else
            // lj_bit holds the left-justified stream; din trails it by one BCLK.
            lj_bit   <= shreg_nxt[FRAME-1];
            i2s_din  <= lj_bit;
`endif
         end
      end
   end

endmodule
